sprite_anim_renderer: RTL and testbench

// Draws one animated, integer-scaled sprite at a programmable screen position over a background colour.

---
 rtl/sprite_pkg.sv | 17 +
 rtl/sprite_anim_palette.sv | 20 ++
 rtl/sprite_anim_renderer.sv | 161 ++++++++++++++++
 tb/tb_sprite_anim_renderer.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sprite_pkg.sv
// Shared defaults and types for the animated sprite renderer and its palette.
package sprite_pkg;

    localparam int SPR_W_DEF      = 16;
    localparam int SPR_H_DEF      = 16;
    localparam int FRAMES_DEF     = 4;
    localparam int IDX_W_DEF      = 8;
    localparam int TRANSP_IDX_DEF = 0;

    typedef logic [11:0] rgb12_t;

    // Counter width that stays legal when the count range collapses to a single value.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sprite_anim_palette.sv
// Combinational palette: maps a texel palette index to a 12-bit {r,g,b} colour.
module sprite_anim_palette
    import sprite_pkg::*;
#(
    parameter int IDX_W = IDX_W_DEF
) (
    input  logic [IDX_W-1:0] idx,
    output rgb12_t           rgb
);

    logic [7:0] idx8;

    assign idx8 = 8'(idx);

    // Low nibble drives red and its complement blue; high nibble drives green.
    always_comb begin
        rgb = {idx8[3:0], idx8[7:4], ~idx8[3:0]};
    end

endmodule

// File: rtl/sprite_anim_renderer.sv
// Draws one animated, shift-scaled sprite over a background colour with a 2-cycle
// DrawX/DrawY -> RGB pipeline and positions/animation latched only at frame_start.
module sprite_anim_renderer
    import sprite_pkg::*;
#(
    parameter int SPR_W       = SPR_W_DEF,
    parameter int SPR_H       = SPR_H_DEF,
    parameter int FRAMES      = FRAMES_DEF,
    parameter int SCALE_LOG2  = 1,
    parameter int FRAME_TICKS = 8,
    parameter int IDX_W       = IDX_W_DEF,
    parameter int TRANSP_IDX  = TRANSP_IDX_DEF,
    localparam int ADDR_W     = $clog2(SPR_W * SPR_H * FRAMES)
) (
    input  logic              vga_clk,
    input  logic              reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              blank,
    input  logic              frame_start,
    input  logic [9:0]        pos_x,
    input  logic [9:0]        pos_y,
    input  logic              mirror_x,
    input  logic              anim_en,
    input  rgb12_t            bg_rgb,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [IDX_W-1:0]  rom_q,
    output logic [3:0]        red,
    output logic [3:0]        green,
    output logic [3:0]        blue,
    output logic              sprite_hit
);

    // SPR_W must be a power of two so row*SPR_W is a concatenation and mirroring is a bit flip.
    localparam int COL_W  = $clog2(SPR_W);
    localparam int ROW_W  = clog2_min1(SPR_H);
    localparam int TICK_W = clog2_min1(FRAME_TICKS);
    localparam int FIDX_W = clog2_min1(FRAMES);

    localparam logic [10:0]       BOX_W      = 11'(SPR_W << SCALE_LOG2);
    localparam logic [10:0]       BOX_H      = 11'(SPR_H << SCALE_LOG2);
    localparam logic [ADDR_W-1:0] FRAME_SIZE = ADDR_W'(SPR_W * SPR_H);
    localparam logic [TICK_W-1:0] TICK_LAST  = TICK_W'(FRAME_TICKS - 1);
    localparam logic [FIDX_W-1:0] FRAME_LAST = FIDX_W'(FRAMES - 1);

    logic [9:0]        shadow_x;
    logic [9:0]        shadow_y;
    logic              shadow_mirror;
    logic [TICK_W-1:0] tick_cnt;
    logic [FIDX_W-1:0] frame_idx;
    logic [ADDR_W-1:0] frame_base;

    logic [10:0]       x_ext;
    logic [10:0]       y_ext;
    logic [10:0]       sx_ext;
    logic [10:0]       sy_ext;
    logic [10:0]       dx;
    logic [10:0]       dy;
    logic              in_box;
    logic [COL_W-1:0]  col_raw;
    logic [COL_W-1:0]  col;
    logic [ROW_W-1:0]  row;
    logic [ADDR_W-1:0] addr_next;

    logic              in_box_d;
    logic              blank_d;
    rgb12_t            palette_rgb;
    rgb12_t            rgb_q;
    logic              hit_q;

    // Everything the frame depends on is latched in vblank, so a frame never mixes two states.
    // frame_base tracks frame_idx*SPR_W*SPR_H incrementally to avoid a multiplier.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            shadow_x      <= '0;
            shadow_y      <= '0;
            shadow_mirror <= 1'b0;
            tick_cnt      <= '0;
            frame_idx     <= '0;
            frame_base    <= '0;
        end else if (frame_start) begin
            shadow_x      <= pos_x;
            shadow_y      <= pos_y;
            shadow_mirror <= mirror_x;
            if (anim_en) begin
                if (tick_cnt == TICK_LAST) begin
                    tick_cnt <= '0;
                    if (frame_idx == FRAME_LAST) begin
                        frame_idx  <= '0;
                        frame_base <= '0;
                    end else begin
                        frame_idx  <= frame_idx + FIDX_W'(1);
                        frame_base <= frame_base + FRAME_SIZE;
                    end
                end else begin
                    tick_cnt <= tick_cnt + TICK_W'(1);
                end
            end
        end
    end

    // 11-bit window arithmetic: a sprite hanging off the right/bottom edge clips instead of wrapping.
    assign x_ext  = {1'b0, DrawX};
    assign y_ext  = {1'b0, DrawY};
    assign sx_ext = {1'b0, shadow_x};
    assign sy_ext = {1'b0, shadow_y};
    assign dx     = x_ext - sx_ext;
    assign dy     = y_ext - sy_ext;

    assign in_box = (x_ext >= sx_ext) && (x_ext < sx_ext + BOX_W) &&
                    (y_ext >= sy_ext) && (y_ext < sy_ext + BOX_H);

    assign col_raw   = COL_W'(dx >> SCALE_LOG2);
    assign col       = shadow_mirror ? ~col_raw : col_raw;
    assign row       = ROW_W'(dy >> SCALE_LOG2);
    assign addr_next = frame_base + ADDR_W'({row, col});

    // The registered address is the ROM's input register, so rom_q lines up with in_box_d/blank_d.
    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            rom_address <= '0;
            in_box_d    <= 1'b0;
            blank_d     <= 1'b0;
        end else begin
            if (in_box) begin
                rom_address <= addr_next;
            end
            in_box_d <= in_box;
            blank_d  <= blank;
        end
    end

    sprite_anim_palette #(
        .IDX_W (IDX_W)
    ) u_palette (
        .idx (rom_q),
        .rgb (palette_rgb)
    );

    always_ff @(posedge vga_clk) begin
        if (!reset_n) begin
            rgb_q <= '0;
            hit_q <= 1'b0;
        end else if (!blank_d) begin
            rgb_q <= '0;
            hit_q <= 1'b0;
        end else if (in_box_d && (rom_q != IDX_W'(TRANSP_IDX))) begin
            rgb_q <= palette_rgb;
            hit_q <= 1'b1;
        end else begin
            rgb_q <= bg_rgb;
            hit_q <= 1'b0;
        end
    end

    assign red        = rgb_q[11:8];
    assign green      = rgb_q[7:4];
    assign blue       = rgb_q[3:0];
    assign sprite_hit = hit_q;

endmodule

// File: tb/tb_sprite_anim_renderer.sv
// Directed bench for sprite_anim_renderer: per-cycle check against a pixel-level model
// plus hand-computed pixel/address expectations.
module tb_sprite_anim_renderer;

    localparam int SW     = 16;
    localparam int SH     = 16;
    localparam int NFR    = 4;
    localparam int SCALE  = 2;
    localparam int TICKS  = 2;
    localparam int ADDR_W = 10;
    localparam int IDLE_Y = 1000;

    logic              vga_clk;
    logic              reset_n;
    logic [9:0]        DrawX;
    logic [9:0]        DrawY;
    logic              blank;
    logic              frame_start;
    logic [9:0]        pos_x;
    logic [9:0]        pos_y;
    logic              mirror_x;
    logic              anim_en;
    logic [11:0]       bg_rgb;
    logic [ADDR_W-1:0] rom_address;
    logic [7:0]        rom_q;
    logic [3:0]        red;
    logic [3:0]        green;
    logic [3:0]        blue;
    logic              sprite_hit;

    logic [7:0]        rom_mem [1024];

    int                vectors;
    int                miscompares;

    // Model state: what the screen should show, from the sprite rules.
    bit                model_ready;
    int                m_sx;
    int                m_sy;
    bit                m_mir;
    int                m_pulses;
    int                m_addr;
    bit                m_inb1;
    bit                m_blank1;
    logic [11:0]       m_rgb;
    bit                m_hit;

    logic [ADDR_W-1:0] probe_addr;
    logic [11:0]       probe_rgb;
    logic              probe_hit;

    sprite_anim_renderer #(
        .SPR_W       (16),
        .SPR_H       (16),
        .FRAMES      (4),
        .SCALE_LOG2  (1),
        .FRAME_TICKS (2),
        .IDX_W       (8),
        .TRANSP_IDX  (0)
    ) dut (
        .vga_clk     (vga_clk),
        .reset_n     (reset_n),
        .DrawX       (DrawX),
        .DrawY       (DrawY),
        .blank       (blank),
        .frame_start (frame_start),
        .pos_x       (pos_x),
        .pos_y       (pos_y),
        .mirror_x    (mirror_x),
        .anim_en     (anim_en),
        .bg_rgb      (bg_rgb),
        .rom_address (rom_address),
        .rom_q       (rom_q),
        .red         (red),
        .green       (green),
        .blue        (blue),
        .sprite_hit  (sprite_hit)
    );

    // The registered rom_address acts as the ROM's address register.
    assign rom_q = rom_mem[rom_address];

    initial begin
        vga_clk = 1'b0;
        forever #5 vga_clk = ~vga_clk;
    end

    function automatic logic [11:0] pal(input logic [7:0] i);
        return {i[3:0], i[7:4], ~i[3:0]};
    endfunction

    // Pixel-level model: the output after this edge shows the pixel presented one cycle earlier.
    always @(posedge vga_clk) begin
        int  x;
        int  y;
        int  col;
        int  row;
        bit  inb;
        if (!reset_n) begin
            model_ready = 1'b1;
            m_sx = 0; m_sy = 0; m_mir = 1'b0; m_pulses = 0;
            m_addr = 0; m_inb1 = 1'b0; m_blank1 = 1'b0;
            m_rgb = 12'h000; m_hit = 1'b0;
        end else begin
            if (!m_blank1) begin
                m_rgb = 12'h000; m_hit = 1'b0;
            end else if (m_inb1 && rom_mem[m_addr] != 8'd0) begin
                m_rgb = pal(rom_mem[m_addr]); m_hit = 1'b1;
            end else begin
                m_rgb = bg_rgb; m_hit = 1'b0;
            end
            x   = int'(DrawX);
            y   = int'(DrawY);
            inb = (x >= m_sx) && (x < m_sx + SW * SCALE) && (y >= m_sy) && (y < m_sy + SH * SCALE);
            if (inb) begin
                col = (x - m_sx) / SCALE;
                if (m_mir) col = SW - 1 - col;
                row = (y - m_sy) / SCALE;
                m_addr = ((m_pulses / TICKS) % NFR) * SW * SH + row * SW + col;
            end
            m_inb1   = inb;
            m_blank1 = blank;
            if (frame_start) begin
                m_sx  = int'(pos_x);
                m_sy  = int'(pos_y);
                m_mir = mirror_x;
                if (anim_en) m_pulses++;
            end
        end
    end

    task automatic clk_step();
        @(posedge vga_clk);
        #1;
        if (model_ready) begin
            vectors++;
            if ({red, green, blue} !== m_rgb || sprite_hit !== m_hit) begin
                miscompares++;
                $display("[TB] FAIL model_pixel t=%0t: got rgb=%h hit=%b, expected rgb=%h hit=%b",
                         $time, {red, green, blue}, sprite_hit, m_rgb, m_hit);
            end
            vectors++;
            if (rom_address !== ADDR_W'(m_addr)) begin
                miscompares++;
                $display("[TB] FAIL model_addr t=%0t: got %0d, expected %0d", $time, rom_address, m_addr);
            end
        end
    endtask

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, got, exp);
        end
    endtask

    task automatic apply_stimulus(input int x, input int y, input logic bl);
        DrawX = 10'(x);
        DrawY = 10'(y);
        blank = bl;
    endtask

    // Present one pixel, capture its ROM address one cycle later and its colour two cycles later.
    task automatic probe(input int x, input int y, input logic bl);
        apply_stimulus(x, y, bl);
        clk_step();
        probe_addr = rom_address;
        apply_stimulus(0, IDLE_Y, 1'b1);
        clk_step();
        probe_rgb = {red, green, blue};
        probe_hit = sprite_hit;
    endtask

    task automatic pulse();
        frame_start = 1'b1;
        clk_step();
        frame_start = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        model_ready = 1'b0;
        for (int a = 0; a < 1024; a++) begin
            rom_mem[a] = (a % 11 == 3) ? 8'h00 : 8'((a * 3 + 5) & 255);
        end

        reset_n = 1'b0; frame_start = 1'b0;
        pos_x = '0; pos_y = '0; mirror_x = 1'b0; anim_en = 1'b0;
        bg_rgb = 12'h123;
        apply_stimulus(0, IDLE_Y, 1'b1);
        repeat (3) clk_step();
        check_output("reset_pixel", {red, green, blue, sprite_hit}, 32'h0);
        check_output("reset_addr", rom_address, 32'd0);

        $display("[TB] basic placement at (100,50)");
        reset_n = 1'b1; pos_x = 10'd100; pos_y = 10'd50;
        pulse();
        probe(100, 50, 1'b1);
        check_output("origin_addr", probe_addr, 32'd0);
        check_output("origin_pixel", {probe_rgb, probe_hit}, {12'h50A, 1'b1});
        probe(131, 81, 1'b1);
        check_output("corner_addr", probe_addr, 32'd255);
        check_output("corner_pixel", {probe_rgb, probe_hit}, {12'h20D, 1'b1});
        probe(132, 81, 1'b1);
        check_output("right_edge_addr_hold", probe_addr, 32'd255);
        check_output("right_edge_pixel", {probe_rgb, probe_hit}, {12'h123, 1'b0});
        probe(106, 50, 1'b1);
        check_output("transp_addr", probe_addr, 32'd3);
        check_output("transp_pixel", {probe_rgb, probe_hit}, {12'h123, 1'b0});
        probe(100, 50, 1'b0);
        check_output("blank_pixel", {probe_rgb, probe_hit}, 32'h0);

        $display("[TB] mirror");
        mirror_x = 1'b1;
        pulse();
        probe(100, 50, 1'b1);
        check_output("mirror_addr", probe_addr, 32'd15);
        check_output("mirror_pixel", {probe_rgb, probe_hit}, {12'h23D, 1'b1});
        mirror_x = 1'b0;
        pulse();

        $display("[TB] animation");
        anim_en = 1'b1;
        repeat (2) pulse();
        probe(100, 50, 1'b1);
        check_output("anim_base1", probe_addr, 32'd256);
        anim_en = 1'b0;
        repeat (4) pulse();
        probe(100, 50, 1'b1);
        check_output("anim_frozen", probe_addr, 32'd256);
        anim_en = 1'b1;
        repeat (6) pulse();
        probe(100, 50, 1'b1);
        check_output("anim_wrap", probe_addr, 32'd0);
        anim_en = 1'b0;

        $display("[TB] tear-free position latch");
        pos_x = 10'd300;
        probe(100, 50, 1'b1);
        check_output("old_pos_pixel", {probe_rgb, probe_hit}, {12'h50A, 1'b1});
        probe(300, 50, 1'b1);
        check_output("new_pos_early", {probe_rgb, probe_hit}, {12'h123, 1'b0});
        pulse();
        probe(300, 50, 1'b1);
        check_output("new_pos_pixel", {probe_rgb, probe_hit}, {12'h50A, 1'b1});
        probe(100, 50, 1'b1);
        check_output("old_pos_gone", {probe_rgb, probe_hit}, {12'h123, 1'b0});

        $display("[TB] right-edge clipping");
        pos_x = 10'd630;
        pulse();
        probe(639, 50, 1'b1);
        check_output("clip_addr", probe_addr, 32'd4);
        check_output("clip_pixel", {probe_rgb, probe_hit}, {12'h11E, 1'b1});
        probe(0, 50, 1'b1);
        check_output("no_wrap_x0", {probe_rgb, probe_hit}, {12'h123, 1'b0});
        probe(1, 50, 1'b1);
        check_output("no_wrap_x1", {probe_rgb, probe_hit}, {12'h123, 1'b0});

        $display("[TB] reset mid-line");
        anim_en = 1'b1;
        repeat (2) pulse();
        anim_en = 1'b0;
        pos_x = 10'd300; pos_y = 10'd40;
        apply_stimulus(110, 60, 1'b1);
        reset_n = 1'b0;
        frame_start = 1'b1;
        clk_step();
        check_output("midline_reset_pixel", {red, green, blue, sprite_hit}, 32'h0);
        check_output("midline_reset_addr", rom_address, 32'd0);
        reset_n = 1'b1;
        frame_start = 1'b0;
        probe(0, 0, 1'b1);
        check_output("post_reset_addr", probe_addr, 32'd0);
        check_output("post_reset_pixel", {probe_rgb, probe_hit}, {12'h50A, 1'b1});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
